// File: rtl/cam_ctrl.sv
// rtl/cam_ctrl.sv - command sequencer in front of a CAM with valid bitmap and hit statistics
//
// Purpose:
//   Accepts write / search / invalidate commands, drives the CAM pins, waits a
//   fixed search latency, then returns a masked, registered search response.
//   A per-entry valid bitmap suppresses hits on entries that were never
//   written through this block or that have since been invalidated.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake (cmd_ready high only in IDLE)
//   cmd_op                    00 search, 01 write, 10 invalidate, 11 reserved
//   cmd_data, cmd_addr        write/search key, write/invalidate address
//   resp_valid / resp_ready   search response handshake
//   resp_hit, resp_addr       masked hit flag and hit address (0 on miss)
//   cam_write_enable, cam_start, cam_din, cam_write_addr   to the CAM
//   cam_match, cam_match_addr                             from the CAM
//   search_count, hit_count   saturating statistics

module cam_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6,
    parameter int SEARCH_LAT = 2,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_hit,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic                  cam_write_enable,
    output logic                  cam_start,
    output logic [DATA_WIDTH-1:0] cam_din,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr,
    output logic [STAT_WIDTH-1:0] search_count,
    output logic [STAT_WIDTH-1:0] hit_count
);

    localparam int ENTRIES = 1 << ADDR_WIDTH;

    localparam logic [1:0] OP_SEARCH = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;

    // The counter is loaded with SEARCH_LAT-1 so cam_start stays high for
    // exactly SEARCH_LAT cycles; match is sampled in the last of them.
    localparam logic [3:0] LAT_LOAD = 4'(SEARCH_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SEARCH,
        RESP
    } state_t;

    state_t                  state_q;
    logic [3:0]              lat_q;
    logic [ENTRIES-1:0]      valid_map_q;
    logic                    resp_valid_q;
    logic                    resp_hit_q;
    logic [ADDR_WIDTH-1:0]   resp_addr_q;
    logic                    cam_we_q;
    logic                    cam_start_q;
    logic [DATA_WIDTH-1:0]   cam_din_q;
    logic [ADDR_WIDTH-1:0]   cam_waddr_q;
    logic [STAT_WIDTH-1:0]   search_count_q;
    logic [STAT_WIDTH-1:0]   hit_count_q;

    logic                    hit_d;
    logic [ADDR_WIDTH-1:0]   hit_addr_d;

    // Only the entry the CAM reports is checked against the bitmap; a masked
    // hit is a miss, not a request to look further down the priority order.
    assign hit_d      = cam_match & valid_map_q[cam_match_addr];
    assign hit_addr_d = hit_d ? cam_match_addr : '0;

    // Gated by rst so cmd_ready reads 0 while reset is held, even though the
    // state register already sits in IDLE.
    assign cmd_ready = (state_q == IDLE) & ~rst;

    assign resp_valid       = resp_valid_q;
    assign resp_hit         = resp_hit_q;
    assign resp_addr        = resp_addr_q;
    assign cam_write_enable = cam_we_q;
    assign cam_start        = cam_start_q;
    assign cam_din          = cam_din_q;
    assign cam_write_addr   = cam_waddr_q;
    assign search_count     = search_count_q;
    assign hit_count        = hit_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            lat_q          <= '0;
            valid_map_q    <= '0;
            resp_valid_q   <= 1'b0;
            resp_hit_q     <= 1'b0;
            resp_addr_q    <= '0;
            cam_we_q       <= 1'b0;
            cam_start_q    <= 1'b0;
            cam_din_q      <= '0;
            cam_waddr_q    <= '0;
            search_count_q <= '0;
            hit_count_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        case (cmd_op)
                            OP_WRITE: begin
                                state_q     <= WRITE;
                                cam_we_q    <= 1'b1;
                                cam_din_q   <= cmd_data;
                                cam_waddr_q <= cmd_addr;
                            end
                            OP_SEARCH: begin
                                state_q     <= SEARCH;
                                cam_start_q <= 1'b1;
                                cam_din_q   <= cmd_data;
                                lat_q       <= LAT_LOAD;
                            end
                            OP_INVAL: begin
                                valid_map_q[cmd_addr] <= 1'b0;
                            end
                            default: begin
                                // reserved opcode: consumed, no CAM activity
                            end
                        endcase
                    end
                end

                WRITE: begin
                    // Bitmap is set at the end of the write cycle, so a reset
                    // landing on this edge leaves the entry invalid.
                    valid_map_q[cam_waddr_q] <= 1'b1;
                    cam_we_q                 <= 1'b0;
                    state_q                  <= IDLE;
                end

                SEARCH: begin
                    if (lat_q == 4'd0) begin
                        cam_start_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= hit_d;
                        resp_addr_q  <= hit_addr_d;
                        state_q      <= RESP;
                        if (search_count_q != '1) begin
                            search_count_q <= search_count_q + STAT_WIDTH'(1);
                        end
                        if (hit_d && (hit_count_q != '1)) begin
                            hit_count_q <= hit_count_q + STAT_WIDTH'(1);
                        end
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_ctrl.sv
// tb/tb_cam_ctrl.sv - scoreboard bench for cam_ctrl with a behavioural CAM and reference model

module tb_cam_ctrl;

    localparam int DW      = 128;
    localparam int AW      = 6;
    localparam int SL      = 2;
    localparam int SW      = 4;
    localparam int ENTRIES = 1 << AW;
    localparam int SMAX    = (1 << SW) - 1;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic [AW-1:0] cmd_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_hit;
    logic [AW-1:0] resp_addr;
    logic          cam_write_enable;
    logic          cam_start;
    logic [DW-1:0] cam_din;
    logic [AW-1:0] cam_write_addr;
    logic          cam_match;
    logic [AW-1:0] cam_match_addr;
    logic [SW-1:0] search_count;
    logic [SW-1:0] hit_count;

    cam_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SEARCH_LAT (SL),
        .STAT_WIDTH (SW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_data         (cmd_data),
        .cmd_addr         (cmd_addr),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_hit         (resp_hit),
        .resp_addr        (resp_addr),
        .cam_write_enable (cam_write_enable),
        .cam_start        (cam_start),
        .cam_din          (cam_din),
        .cam_write_addr   (cam_write_addr),
        .cam_match        (cam_match),
        .cam_match_addr   (cam_match_addr),
        .search_count     (search_count),
        .hit_count        (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural CAM (stand-in for the real device) -------
    bit [DW-1:0] cam_mem [ENTRIES];
    bit          cam_wr  [ENTRIES];
    int          cam_cyc = 0;
    bit          junk_match;
    bit [AW-1:0] junk_addr;

    always @(posedge clk) begin
        if (cam_write_enable) begin
            cam_mem[cam_write_addr] <= cam_din;
            cam_wr[cam_write_addr]  <= 1'b1;
        end
        cam_cyc <= cam_start ? cam_cyc + 1 : 0;
    end

    always @(negedge clk) begin
        junk_match <= 1'($urandom);
        junk_addr  <= AW'($urandom);
    end

    // Result is only meaningful in the SL-th cycle of cam_start; other
    // cycles present noise so a wrong sampling point shows up.
    always_comb begin
        cam_match      = junk_match;
        cam_match_addr = junk_addr;
        if (cam_start && (cam_cyc == SL - 1)) begin
            cam_match      = 1'b0;
            cam_match_addr = '0;
            for (int i = ENTRIES - 1; i >= 0; i--) begin
                if (cam_wr[i] && (cam_mem[i] == cam_din)) begin
                    cam_match      = 1'b1;
                    cam_match_addr = AW'(i);
                end
            end
        end
    end

    // ---------------- reference model --------------------------------------
    typedef struct {
        bit          hit;
        bit [AW-1:0] addr;
        int          sc;
        int          hc;
    } exp_t;

    exp_t        exp_q[$];
    bit [DW-1:0] ref_mem [ENTRIES];
    bit          ref_wr  [ENTRIES];
    bit          ref_val [ENTRIES];
    int          exp_sc = 0;
    int          exp_hc = 0;
    bit          hold_bp = 1'b0;

    task automatic model_search(input bit [DW-1:0] k, output exp_t e);
        int idx;
        idx = -1;
        for (int i = 0; i < ENTRIES; i++) begin
            if (idx < 0 && ref_wr[i] && ref_mem[i] == k) idx = i;
        end
        e.hit  = (idx >= 0) ? ref_val[idx] : 1'b0;
        e.addr = e.hit ? AW'(idx) : '0;
        if (exp_sc < SMAX) exp_sc++;
        if (e.hit && exp_hc < SMAX) exp_hc++;
        e.sc = exp_sc;
        e.hc = exp_hc;
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) ref_val[i] = 1'b0;
        exp_sc = 0;
        exp_hc = 0;
        exp_q.delete();
    endtask

    // ---------------- response monitor / scoreboard ------------------------
    initial begin
        exp_t        e;
        bit          pend;
        bit          p_hit;
        bit [AW-1:0] p_addr;
        pend       = 1'b0;
        p_hit      = 1'b0;
        p_addr     = '0;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_bp) resp_ready = 1'b0;
            else         resp_ready = ($urandom_range(0, 3) != 0);
            if (resp_valid && !rst) begin
                check("cmd_ready_in_resp", 128'(cmd_ready), 128'(0));
                if (pend) begin
                    check("resp_hit_stable", 128'(resp_hit), 128'(p_hit));
                    check("resp_addr_stable", 128'(resp_addr), 128'(p_addr));
                end
                if (resp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 128'(1), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_hit", 128'(resp_hit), 128'(e.hit));
                        check("resp_addr", 128'(resp_addr), 128'(e.addr));
                        check("search_count", 128'(search_count), 128'(e.sc));
                        check("hit_count", 128'(hit_count), 128'(e.hc));
                    end
                end
            end
            pend   = resp_valid && !resp_ready;
            p_hit  = resp_hit;
            p_addr = resp_addr;
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept_wait", 128'(cmd_ready), 128'(1));
    endtask

    // Called and returns on a negedge.
    task automatic issue(input bit [1:0] op, input bit [DW-1:0] d, input bit [AW-1:0] a);
        exp_t e;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_addr  = a;
        case (op)
            2'b01: begin ref_mem[a] = d; ref_wr[a] = 1'b1; ref_val[a] = 1'b1; end
            2'b10: ref_val[a] = 1'b0;
            2'b00: begin model_search(d, e); exp_q.push_back(e); end
            default: ;
        endcase
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        case (op)
            2'b01: begin
                check("wr_we_t1", 128'(cam_write_enable), 128'(1));
                check("wr_addr_t1", 128'(cam_write_addr), 128'(a));
                check("wr_din_t1", 128'(cam_din), 128'(d));
                check("wr_ready_t1", 128'(cmd_ready), 128'(0));
                @(negedge clk);
                check("wr_we_t2", 128'(cam_write_enable), 128'(0));
                check("wr_ready_t2", 128'(cmd_ready), 128'(1));
            end
            2'b00: begin
                for (int k = 0; k < SL; k++) begin
                    if (k > 0) @(negedge clk);
                    check("srch_start", 128'(cam_start), 128'(1));
                    check("srch_din", 128'(cam_din), 128'(d));
                    check("srch_we", 128'(cam_write_enable), 128'(0));
                    check("srch_rvalid_early", 128'(resp_valid), 128'(0));
                end
                @(negedge clk);
                check("srch_start_end", 128'(cam_start), 128'(0));
                check("srch_rvalid", 128'(resp_valid), 128'(1));
            end
            default: begin
                check("nowr_ready", 128'(cmd_ready), 128'(1));
                check("nowr_we", 128'(cam_write_enable), 128'(0));
                check("nowr_start", 128'(cam_start), 128'(0));
            end
        endcase
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || resp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cmd_ready"}, 128'(cmd_ready), 128'(0));
        check({tag, "_resp_valid"}, 128'(resp_valid), 128'(0));
        check({tag, "_resp_hit"}, 128'(resp_hit), 128'(0));
        check({tag, "_resp_addr"}, 128'(resp_addr), 128'(0));
        check({tag, "_cam_we"}, 128'(cam_write_enable), 128'(0));
        check({tag, "_cam_start"}, 128'(cam_start), 128'(0));
        check({tag, "_cam_din"}, 128'(cam_din), 128'(0));
        check({tag, "_cam_waddr"}, 128'(cam_write_addr), 128'(0));
        check({tag, "_search_count"}, 128'(search_count), 128'(0));
        check({tag, "_hit_count"}, 128'(hit_count), 128'(0));
    endtask

    // Reset lands on the edge ending the first cycle after acceptance.
    task automatic reset_in_flight(input bit [1:0] op, input bit [DW-1:0] d, input bit [AW-1:0] a);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_addr  = a;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (op == 2'b01) begin
            check("rst_wr_we", 128'(cam_write_enable), 128'(1));
            ref_mem[a] = d;
            ref_wr[a]  = 1'b1;
        end else begin
            check("rst_srch_start", 128'(cam_start), 128'(1));
        end
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        check_zero("rst_mid");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_resp", 128'(resp_valid), 128'(0));
            check("rst_ready", 128'(cmd_ready), 128'(1));
        end
    endtask

    initial begin
        bit [DW-1:0] pool [6];
        bit [DW-1:0] key;
        bit [AW-1:0] adr;
        int          r;
        int          n;

        for (int i = 0; i < 6; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        cmd_addr  = '0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 128'(cmd_ready), 128'(1));

        // write then hit
        issue(2'b01, DW'(128'h1234), AW'(5));
        issue(2'b00, DW'(128'h1234), '0);
        drain();
        // miss
        issue(2'b00, DW'(128'hBEEF), '0);
        drain();
        // write, invalidate, masked CAM hit
        issue(2'b01, DW'(128'hAA), AW'(3));
        issue(2'b10, '0, AW'(3));
        issue(2'b10, '0, AW'(3));
        issue(2'b00, DW'(128'hAA), '0);
        drain();

        // long back-pressure on a hit
        hold_bp = 1'b1;
        issue(2'b00, DW'(128'h1234), '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rvalid", 128'(resp_valid), 128'(1));
            check("bp_ready", 128'(cmd_ready), 128'(0));
        end
        hold_bp = 1'b0;
        n = 0;
        while (resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_release", 128'(resp_valid), 128'(0));
        check("bp_ready_after", 128'(cmd_ready), 128'(1));
        drain();

        // saturation of both counters, then a reserved opcode
        for (int i = 0; i < SMAX + 3; i++) issue(2'b00, DW'(128'h1234), '0);
        drain();
        check("sat_search_count", 128'(search_count), 128'(SMAX));
        check("sat_hit_count", 128'(hit_count), 128'(SMAX));
        issue(2'b11, DW'(128'h55), AW'(7));
        check("op11_search_count", 128'(search_count), 128'(SMAX));

        // reset during SEARCH and during WRITE
        reset_in_flight(2'b00, DW'(128'h1234), '0);
        reset_in_flight(2'b01, DW'(128'hC0FFEE), AW'(9));
        issue(2'b00, DW'(128'hC0FFEE), '0);
        drain();

        // randomized traffic
        for (int t = 0; t < 300; t++) begin
            r   = $urandom_range(0, 99);
            key = pool[$urandom_range(0, 5)];
            adr = ($urandom_range(0, 9) == 0) ? AW'(ENTRIES - 1) : AW'($urandom_range(0, 11));
            if (r < 35)      issue(2'b01, key, adr);
            else if (r < 75) issue(2'b00, key, adr);
            else if (r < 95) issue(2'b10, key, adr);
            else             issue(2'b11, key, adr);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
